pdl_puf_sequencer: RTL and testbench

Challenge/response sequencer that drives a PDL arbiter PUF instance from the fabric side. It accepts a 64-bit seed challenge through a valid/ready request port and steps a 64-bit LFSR to produce RESP_BITS challenges. For each challenge it clears the arbiter, launches the race, samples the response VOTES times, and majority-votes the samples into one bit. The assembled response word is returned on a valid/ready response port. It replaces switch/LED stimulus of the PUF with a clocked, repeatable driver.

---
 rtl/pdl_pkg.sv | 26 ++
 rtl/pdl_chal_lfsr.sv | 37 +++
 rtl/pdl_puf_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pdl_puf_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdl_pkg.sv
// Shared definitions for the PDL arbiter-PUF challenge/response sequencer.
//   - sequencer state encoding
//   - challenge width and LFSR tap constant (taps at bits 63/62/60/59)
//   - lfsr_feedback(): XOR of the tapped challenge bits
package pdl_pkg;

    localparam int CHAL_WIDTH = 64;

    // Taps 63, 62, 60, 59 of the challenge LFSR.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Feedback bit of the challenge LFSR: parity of the tapped bits.
    function automatic logic lfsr_feedback(input logic [CHAL_WIDTH-1:0] chal);
        return ^(chal & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/pdl_chal_lfsr.sv
// 64-bit challenge register for the PDL PUF.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (state -> 0)
//   i_load       load i_seed (takes priority over i_step)
//   i_seed       seed challenge
//   i_step       advance one LFSR step: c <= {c[62:0], fb}
//   o_state      current challenge (registered)
// A zero seed is kept as-is, so the register stays at zero while stepping.
module pdl_chal_lfsr
    import pdl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [CHAL_WIDTH-1:0] i_seed,
    input  logic                  i_step,
    output logic [CHAL_WIDTH-1:0] o_state
);

    logic [CHAL_WIDTH-1:0] r_state;

    // Challenge register: load a seed, or shift in the feedback bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= {CHAL_WIDTH{1'b0}};
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= {r_state[CHAL_WIDTH-2:0], lfsr_feedback(r_state)};
        end else begin
            r_state <= r_state;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/pdl_puf_sequencer.sv
// Challenge/response sequencer driving a PDL arbiter PUF.
// A seed accepted on the request port is stepped through RESP_BITS LFSR
// challenges. Each challenge is evaluated VOTES times (clear arbiter,
// launch race, wait, sample the synchronized response) and majority-voted
// into one response bit. The word is returned on the response port.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   req_valid/req_ready     seed handshake (ready only in IDLE)
//   req_seed                64-bit seed challenge
//   resp_valid/resp_ready   response handshake; data held until taken
//   resp_data               bit i = voted response to challenge i
//   busy                    request in progress
//   chal_top/chal_bottom    PDL line configurations (identical)
//   puf_reset               arbiter clear, active-high
//   race                    race launch; rising edge starts both lines
//   puf_response            asynchronous arbiter output
module pdl_puf_sequencer
    import pdl_pkg::*;
#(
    parameter int RESP_BITS     = 16,
    parameter int VOTES         = 5,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CHAL_WIDTH-1:0] req_seed,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [RESP_BITS-1:0]  resp_data,
    output logic                  busy,
    output logic [CHAL_WIDTH-1:0] chal_top,
    output logic [CHAL_WIDTH-1:0] chal_bottom,
    output logic                  puf_reset,
    output logic                  race,
    input  logic                  puf_response
);

    localparam int BW      = $clog2(RESP_BITS) + 1;
    localparam int IW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int VW      = $clog2(VOTES) + 1;
    localparam int CMAX    = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CMAX) + 1;

    localparam logic [BW-1:0] LAST_BIT     = BW'(RESP_BITS - 1);
    localparam logic [VW-1:0] VOTES_V      = VW'(VOTES);
    localparam logic [VW-1:0] HALF_V       = VW'(VOTES / 2);
    localparam logic [CW-1:0] CLEAR_LAST   = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    state_e                 r_state;
    logic [BW-1:0]          r_bit_cnt;
    logic [VW-1:0]          r_vote_cnt;
    logic [VW-1:0]          r_ones_cnt;
    logic [CW-1:0]          r_cyc_cnt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_req_ready;
    logic                   r_resp_valid;
    logic [RESP_BITS-1:0]   r_resp_data;
    logic                   r_busy;
    logic                   r_puf_reset;
    logic                   r_race;

    logic                   w_load;
    logic                   w_step;
    logic [CHAL_WIDTH-1:0]  w_chal;

    // LFSR is loaded on seed acceptance and stepped once per finished challenge.
    assign w_load = (r_state == ST_IDLE) && req_valid;
    assign w_step = (r_state == ST_NEXT);

    pdl_chal_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_seed  (req_seed),
        .i_step  (w_step),
        .o_state (w_chal)
    );

    // Two-flop synchronizer for the asynchronous arbiter output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= puf_response;
            r_sync2 <= r_sync1;
        end
    end

    // Sequencer FSM with counters and registered handshake/PUF controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= {BW{1'b0}};
            r_vote_cnt   <= {VW{1'b0}};
            r_ones_cnt   <= {VW{1'b0}};
            r_cyc_cnt    <= {CW{1'b0}};
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= {RESP_BITS{1'b0}};
            r_busy       <= 1'b0;
            r_puf_reset  <= 1'b1;
            r_race       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state     <= ST_CLEAR;
                        r_bit_cnt   <= {BW{1'b0}};
                        r_vote_cnt  <= {VW{1'b0}};
                        r_ones_cnt  <= {VW{1'b0}};
                        r_cyc_cnt   <= {CW{1'b0}};
                        r_resp_data <= {RESP_BITS{1'b0}};
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (r_cyc_cnt == CLEAR_LAST) begin
                        r_state     <= ST_LAUNCH;
                        r_cyc_cnt   <= {CW{1'b0}};
                        r_puf_reset <= 1'b0;
                        r_race      <= 1'b1;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_LAUNCH: begin
                    if (r_cyc_cnt == SETTLE_LAST) begin
                        r_state   <= ST_SAMPLE;
                        r_cyc_cnt <= {CW{1'b0}};
                        r_race    <= 1'b0;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_SAMPLE: begin
                    r_ones_cnt  <= r_ones_cnt + {{(VW-1){1'b0}}, r_sync2};
                    r_vote_cnt  <= r_vote_cnt + {{(VW-1){1'b0}}, 1'b1};
                    // Arbiter goes back into clear for the next vote or challenge.
                    r_puf_reset <= 1'b1;
                    if ((r_vote_cnt + {{(VW-1){1'b0}}, 1'b1}) < VOTES_V) begin
                        r_state <= ST_CLEAR;
                    end else begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_resp_data[r_bit_cnt[IW-1:0]] <= (r_ones_cnt > HALF_V);
                    r_vote_cnt <= {VW{1'b0}};
                    r_ones_cnt <= {VW{1'b0}};
                    r_bit_cnt  <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
                    if (r_bit_cnt == LAST_BIT) begin
                        r_state      <= ST_DONE;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_puf_reset  <= 1'b1;
                    r_race       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign busy        = r_busy;
    assign chal_top    = w_chal;
    assign chal_bottom = w_chal;
    assign puf_reset   = r_puf_reset;
    assign race        = r_race;

endmodule

// File: tb/tb_pdl_puf_sequencer.sv
module tb_pdl_puf_sequencer;

    localparam int RB  = 16;
    localparam int V   = 5;
    localparam int LAT = RB * (V * (4 + 16 + 1) + 1);   // 1696 cycles

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_seed;
    logic          resp_valid;
    logic          resp_ready;
    logic [RB-1:0] resp_data;
    logic          busy;
    logic [63:0]   chal_top;
    logic [63:0]   chal_bottom;
    logic          puf_reset;
    logic          race;
    logic          puf_response;

    pdl_puf_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_seed     (req_seed),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .busy         (busy),
        .chal_top     (chal_top),
        .chal_bottom  (chal_bottom),
        .puf_reset    (puf_reset),
        .race         (race),
        .puf_response (puf_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks;
    int            errors;
    longint        cyc;
    longint        accept_cyc;
    bit            vote_bits [RB*V];
    logic [63:0]   exp_chal  [RB];
    logic [RB-1:0] exp_q [$];
    int            launch_idx;
    bit            prev_valid;
    logic [RB-1:0] held_data;
    logic [63:0]   launch_chal;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: majority of the prepared vote bits, challenge list by LFSR rule.
    function automatic logic [RB-1:0] model_word();
        logic [RB-1:0] w;
        w = '0;
        for (int i = 0; i < RB; i++) begin
            int ones;
            ones = 0;
            for (int v = 0; v < V; v++) ones += int'(vote_bits[i*V+v]);
            w[i] = (2 * ones > V);
        end
        return w;
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] c);
        return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  64'(req_ready),  64'd1);
        check({tag, "_puf_reset"},  64'(puf_reset),  64'd1);
        check({tag, "_race"},       64'(race),       64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"},  64'(resp_data),  64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_chal_top"},   chal_top,        64'd0);
        check({tag, "_chal_bot"},   chal_bottom,     64'd0);
    endtask

    task automatic issue(input logic [63:0] seed);
        logic [63:0] c;
        int k;
        c = seed;
        for (int i = 0; i < RB; i++) begin
            exp_chal[i] = c;
            c = lfsr_next(c);
        end
        exp_q.push_back(model_word());
        launch_idx = 0;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_seed  = seed;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && exp_q.size() > 0; k++) @(negedge clk);
        check("resp_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_votes_const(input bit b);
        for (int i = 0; i < RB*V; i++) vote_bits[i] = b;
    endtask

    task automatic set_votes_random();
        for (int i = 0; i < RB*V; i++) vote_bits[i] = 1'($urandom_range(0, 1));
    endtask

    // PUF model: at each launch, present the prepared vote bit and check the challenge.
    initial begin
        puf_response = 1'b0;
        forever begin
            @(posedge race);
            #1;
            launch_chal = chal_top;
            if (launch_idx < RB*V) begin
                puf_response = vote_bits[launch_idx];
                check("chal_top", chal_top, exp_chal[launch_idx / V]);
            end
            check("chal_bottom", chal_bottom, chal_top);
            launch_idx++;
        end
    end

    // Challenge must not move while the race is in flight.
    initial begin
        forever begin
            @(negedge race);
            if (reset) check("chal_stable_race", chal_top, launch_chal);
        end
    end

    // Response monitor: pop the scoreboard on each new response, check holds otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    check("resp_data", 64'(resp_data), 64'(exp_q.pop_front()));
                end
                check("resp_latency", 64'(cyc - accept_cyc), 64'(LAT));
                held_data = resp_data;
            end else if (resp_valid && prev_valid) begin
                check("hold_data",      64'(resp_data), 64'(held_data));
                check("hold_req_ready", 64'(req_ready), 64'd0);
                check("hold_busy",      64'(busy),      64'd1);
            end
            prev_valid = resp_valid;
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        accept_cyc = 0;
        launch_idx = 0;
        prev_valid = 1'b0;
        held_data  = '0;
        launch_chal = '0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_seed   = 64'd0;
        resp_ready = 1'b1;
        for (int i = 0; i < RB; i++) exp_chal[i] = 64'd0;

        repeat (3) @(negedge clk);
        check_reset_values("rst_in");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("rst_out");

        // All-ones and all-zeros PUF with seed 1.
        set_votes_const(1'b1);
        issue(64'h1);
        wait_done();
        set_votes_const(1'b0);
        issue(64'h1);
        wait_done();

        // Majority: bit 0 gets 3 of 5 ones, all others 2 of 5.
        set_votes_const(1'b0);
        for (int i = 0; i < RB; i++) begin
            vote_bits[i*V+0] = 1'b1;
            vote_bits[i*V+1] = 1'b1;
        end
        vote_bits[2] = 1'b1;
        check("majority_model", 64'(model_word()), 64'h0001);
        issue(64'h1);
        wait_done();

        // Backpressure: hold resp_ready low for 50 cycles.
        set_votes_random();
        resp_ready = 1'b0;
        issue({$urandom, $urandom});
        wait_done();
        repeat (50) @(negedge clk);
        check("bp_valid_held", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 64'(resp_valid), 64'd0);
        check("bp_req_ready",  64'(req_ready),  64'd1);
        check("bp_busy",       64'(busy),       64'd0);

        // Reset in the middle of a request.
        set_votes_random();
        issue({$urandom, $urandom} | 64'h1);
        repeat (500) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        set_votes_const(1'b1);
        issue(64'h1);
        wait_done();

        // Random seeds and votes, including the zero seed.
        for (int r = 0; r < 4; r++) begin
            set_votes_random();
            if (r == 1) issue(64'h0);
            else        issue({$urandom, $urandom});
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
